// File: rtl/bram_rr_arbiter_pkg.sv
// Shared definitions for the BRAM round-robin arbiter.
//   id_width()   : width of a requester index
//   addr_width() : width of a memory address
//   RD_LATENCY   : cycles from read handshake to read data on the memory output
package bram_rr_arbiter_pkg;

    // Memory read port is registered: data appears one cycle after the read is issued.
    localparam int unsigned RD_LATENCY = 1;

    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   cand       : per-requester candidate vector
//   grant_en   : qualifies all grants (forced low while in reset)
//   grant      : one-hot grant vector (combinational)
//   grant_idx  : index of the granted requester
//   grant_any  : a grant was issued this cycle
// The search starts at the pointer and wraps; after a grant to g the pointer moves to g+1.
module rr_arbiter
    import bram_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] cand,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] scan_idx;
    logic            found;

    // Scan from the pointer upward; the first candidate hit wins.
    always_comb begin
        scan_sum  = '0;
        scan_idx  = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (scan_sum >= (ID_W + 1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W + 1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && cand[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant_any = found & grant_en;
        grant     = '0;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Shares one simple dual-port block RAM among NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-requester request valid
//   req_we     : 1 = write, 0 = read (qualified by req_valid)
//   req_addr   : flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  : flattened write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : combinational grant; transfer when req_valid & req_ready
//   rsp_valid  : one-cycle pulse per completed read
//   rsp_id     : requester that owns rsp_data
//   rsp_data   : read data (memory output register)
// Writes and reads are arbitrated independently, so one of each may complete per cycle.
// N_ADDR must be a power of two so every address is in range.
module bram_rr_arbiter
    import bram_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned N_ADDR     = 256,
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned ADDR_W    = addr_width(N_ADDR),
    localparam int unsigned ID_W      = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data
);

    logic [NUM_REQ-1:0] wr_grant, rd_grant;
    logic [ID_W-1:0]    wr_idx, rd_idx;
    logic               wr_any, rd_any;

    logic [ADDR_W-1:0]     addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_wr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .cand      (req_valid & req_we),
        .grant_en  (rst_n),
        .grant     (wr_grant),
        .grant_idx (wr_idx),
        .grant_any (wr_any)
    );

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rd_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .cand      (req_valid & ~req_we),
        .grant_en  (rst_n),
        .grant     (rd_grant),
        .grant_idx (rd_idx),
        .grant_any (rd_any)
    );

    assign req_ready = wr_grant | rd_grant;

    // Memory port signals driven by the current grantees.
    logic                  mem_wen, mem_ren;
    logic [ADDR_W-1:0]     mem_wadd, mem_radd;
    logic [DATA_WIDTH-1:0] mem_win;

    assign mem_wen  = wr_any;
    assign mem_wadd = addr_arr[wr_idx];
    assign mem_win  = wdata_arr[wr_idx];
    assign mem_ren  = rd_any;
    assign mem_radd = addr_arr[rd_idx];

    // Inferred simple dual-port RAM. Both ports use NBAs on the same edge, so a same-cycle
    // read of the written address returns the old contents.
    logic [DATA_WIDTH-1:0] mem_q [N_ADDR];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (mem_wen) begin
            mem_q[mem_wadd] <= mem_win;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_ren) begin
            rdata_q <= mem_q[mem_radd];
        end
    end

    // Response tag pipeline, kept in step with the memory read latency. Reset clears any
    // read still in flight so it never produces a response.
    logic [RD_LATENCY-1:0] vld_q;
    logic [ID_W-1:0]       id_q [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= rd_any;
            if (rd_any) begin
                id_q[0] <= rd_idx;
            end
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
        end
    end

    assign rsp_valid = vld_q[RD_LATENCY-1];
    assign rsp_id    = id_q[RD_LATENCY-1];
    assign rsp_data  = rdata_q;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a per-cycle reference model.
module tb_bram_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;

    logic [7:0]  a_arr [4];
    logic [15:0] d_arr [4];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_addr[g*8 +: 8]    = a_arr[g];
        assign req_wdata[g*16 +: 16] = d_arr[g];
    end

    bram_rr_arbiter #(
        .NUM_REQ    (4),
        .N_ADDR     (256),
        .DATA_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          wr_ptr_m, rd_ptr_m;
    logic [15:0] mem_m [256];
    bit          known_m [256];
    bit          exp_vld;
    logic [1:0]  exp_id;
    logic [15:0] exp_data;
    bit          exp_known;

    // First candidate at or after ptr, wrapping; -1 if none.
    function automatic int pick(input logic [3:0] cand, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (cand[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready(input logic [3:0] v, input logic [3:0] we,
                                               input int wp, input int rp);
        int wg, rg;
        logic [3:0] r;
        wg = pick(v & we, wp);
        rg = pick(v & ~we, rp);
        for (int i = 0; i < 4; i++) r[i] = (i == wg) || (i == rg);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int wg, rg;
        logic [1:0] wi, ri;
        if (!rst_n) begin
            wr_ptr_m <= 0;
            rd_ptr_m <= 0;
            exp_vld  <= 1'b0;
        end else begin
            wg = pick(req_valid & req_we, wr_ptr_m);
            rg = pick(req_valid & ~req_we, rd_ptr_m);
            exp_vld <= (rg >= 0);
            if (rg >= 0) begin
                ri = 2'(rg);
                exp_id    <= ri;
                exp_data  <= mem_m[a_arr[ri]];
                exp_known <= known_m[a_arr[ri]];
                rd_ptr_m  <= (rg + 1) % 4;
            end
            if (wg >= 0) begin
                wi = 2'(wg);
                mem_m[a_arr[wi]]   <= d_arr[wi];
                known_m[a_arr[wi]] <= 1'b1;
                wr_ptr_m           <= (wg + 1) % 4;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("ready_in_reset", 64'(req_ready), 64'(4'b0000));
            check("rsp_valid_in_reset", 64'(rsp_valid), 64'(1'b0));
        end else begin
            check("req_ready", 64'(req_ready),
                  64'(model_ready(req_valid, req_we, wr_ptr_m, rd_ptr_m)));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
            if (exp_vld) check("rsp_id", 64'(rsp_id), 64'(exp_id));
            if (exp_vld && exp_known) check("rsp_data", 64'(rsp_data), 64'(exp_data));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic drive(input logic [1:0] i, input bit we, input logic [7:0] a,
                         input logic [15:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        a_arr[i]     = a;
        d_arr[i]     = d;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
        end

        // Reset: everyone requesting reads, no grants while held.
        for (int i = 0; i < 4; i++) drive(2'(i), 1'b0, 8'(i), 16'h0);
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'(4'b0000));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", 64'(req_ready), 64'(4'b0001));
        step();
        idle();

        // Write then read back through requester 2.
        drive(2'd2, 1'b1, 8'h10, 16'hBEEF);
        @(negedge clk);
        check("wr_ready_req2", 64'(req_ready), 64'(4'b0100));
        step();
        idle();
        drive(2'd2, 1'b0, 8'h10, 16'h0);
        @(negedge clk);
        check("rd_ready_req2", 64'(req_ready), 64'(4'b0100));
        step();
        idle();
        @(negedge clk);
        check("wr_rd_rsp_valid", 64'(rsp_valid), 64'(1'b1));
        check("wr_rd_rsp_id", 64'(rsp_id), 64'(2'd2));
        check("wr_rd_rsp_data", 64'(rsp_data), 64'(16'hBEEF));

        // Round-robin fairness on reads from a freshly reset pointer.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 1'b1, 8'(i), 16'(16'hA0 + i));
            step();
            idle();
        end
        for (int i = 0; i < 4; i++) drive(2'(i), 1'b0, 8'(i), 16'h0);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << (k % 4);
            @(negedge clk);
            check("rr_grant", 64'(req_ready), 64'(onehot));
            if (k > 0) begin
                check("rr_rsp_id", 64'(rsp_id), 64'(k - 1));
                check("rr_rsp_data", 64'(rsp_data), 64'(16'hA0 + k - 1));
            end
            step();
        end
        idle();
        @(negedge clk);
        check("rr_last_rsp_id", 64'(rsp_id), 64'(2'd0));
        check("rr_last_rsp_data", 64'(rsp_data), 64'(16'hA0));

        // Concurrent write and read of the same address: read sees old data.
        step();
        drive(2'd0, 1'b1, 8'h05, 16'h0000);
        step();
        idle();
        drive(2'd0, 1'b1, 8'h05, 16'h1234);
        drive(2'd3, 1'b0, 8'h05, 16'h0);
        @(negedge clk);
        check("concurrent_ready", 64'(req_ready), 64'(4'b1001));
        step();
        idle();
        drive(2'd3, 1'b0, 8'h05, 16'h0);
        @(negedge clk);
        check("rbw_rsp_id", 64'(rsp_id), 64'(2'd3));
        check("rbw_old_data", 64'(rsp_data), 64'(16'h0000));
        step();
        idle();
        @(negedge clk);
        check("rbw_new_data", 64'(rsp_data), 64'(16'h1234));

        // Pointer wrap and hold on the write arbiter.
        step();
        drive(2'd2, 1'b1, 8'h20, 16'h2222);
        step();
        idle();
        drive(2'd1, 1'b1, 8'h21, 16'h1111);
        @(negedge clk);
        check("wrap_grant_req1", 64'(req_ready), 64'(4'b0010));
        step();
        idle();
        repeat (2) step();
        drive(2'd0, 1'b1, 8'h22, 16'h0);
        drive(2'd2, 1'b1, 8'h23, 16'h0002);
        @(negedge clk);
        check("hold_grant_req2", 64'(req_ready), 64'(4'b0100));
        step();
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("held_req0_granted", 64'(req_ready), 64'(4'b0001));
        step();
        idle();

        // Reset right after a read handshake: that read never responds.
        drive(2'd1, 1'b0, 8'h10, 16'h0);
        @(negedge clk);
        check("pre_reset_read", 64'(req_ready), 64'(4'b0010));
        step();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        check("dropped_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(2'(i), 1'b1, 8'(i), 16'(16'hA0 + i));
        #2;
        check("wr_ptr_after_reset", 64'(req_ready), 64'(4'b0001));
        for (int i = 0; i < 4; i++) drive(2'(i), 1'b0, 8'(i), 16'h0);
        #1;
        check("rd_ptr_after_reset", 64'(req_ready), 64'(4'b0001));
        step();
        idle();
        @(negedge clk);
        check("post_reset_rsp_id", 64'(rsp_id), 64'(2'd0));
        check("post_reset_rsp_data", 64'(rsp_data), 64'(16'hA0));
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Shares one simple dual-port block RAM (one write port, one read port, registered read, 1-cycle latency) among NUM_REQ requesters.
- Write requests and read requests are arbitrated independently with round-robin fairness, so one write and one read can be granted in the same cycle.
- Read data returns on a shared response bus tagged with the requester index.
- Sits between DSP stages (coefficient loaders, accumulators, readback logic) and a shared coefficient/sample memory.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- N_ADDR, 256, memory depth; ADDR_W = $clog2(N_ADDR).
- DATA_WIDTH, 16, word width.
- ID_W, derived, $clog2(NUM_REQ); not user-set.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  1 = write, 0 = read; qualified by req_valid.
- req_addr  in  NUM_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data; ignored for reads.
- req_ready  out  NUM_REQ  combinational grant; transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  1  read data valid pulse.
- rsp_id  out  ID_W  requester index owning rsp_data.
- rsp_data  out  DATA_WIDTH  read data.

Behaviour:
- Two independent round-robin arbiters:
  - Write candidates: req_valid & req_we. Read candidates: req_valid & ~req_we.
  - Each arbiter has a pointer (wr_ptr, rd_ptr).
  - Grant goes to the first candidate found scanning from the pointer upward, with wrap-around.
  - On a grant to index g, the pointer becomes (g+1) mod NUM_REQ next cycle. With no grant, the pointer holds.
- req_ready[i] is a pure combinational function of req_valid, req_we and the pointers. At most one write and at most one read ready per cycle.
- A request not granted must be held stable by the requester; the arbiter never drops a held request.
- Fairness: a continuously valid request is granted within NUM_REQ cycles of assertion.
- Write grant drives the memory write port in the same cycle: wen=1, wadd and win muxed from the grantee.
- Read grant drives the read port in the same cycle: ren=1, radd muxed from the grantee.
  - The grantee index is registered as rsp_id, with rsp_valid=1 on the next cycle.
  - rsp_data is the memory output register. Latency from handshake to rsp_valid is exactly 1 cycle.
  - rsp_valid is a single-cycle pulse per read. Back-to-back reads give consecutive pulses.
- Same-cycle write and read to the same address: read returns the OLD contents (read-before-write). The new value is visible to reads granted on the following cycle or later.
- No backpressure on the response path; consumers must accept rsp_valid whenever it pulses.
- Reset (asynchronous assert, synchronous release):
  - wr_ptr=0, rd_ptr=0, rsp_valid=0, rsp_id=0.
  - req_ready follows reset pointers combinationally; grants are suppressed (req_ready all 0) while rst_n=0.
  - rsp_data is not reset and is undefined until the first rsp_valid.
  - Memory contents are not cleared by reset.
  - A read granted in the cycle before reset assertion produces no rsp_valid.
- No out-of-range addresses are possible, since addresses are ADDR_W wide and N_ADDR is a power of two (required).

Decomposition:
- Shared package: ID_W/ADDR_W derivation functions and a localparam RD_LATENCY=1. Alignment logic uses RD_LATENCY.
- Sub-module rr_arbiter (NUM_REQ param): inputs cand[NUM_REQ] and grant_en; outputs one-hot grant, grant index and grant_any; owns its pointer, clk and rst_n.
  - Instantiated twice (write, read).
- Memory: instantiate the team's existing inferred dual-port BRAM, with rsp_valid/rsp_id pipelined alongside it.

Test Plan:
- Reset check: hold rst_n=0 with all req_valid=1 -> req_ready=0000 and rsp_valid=0. After release, with all requesting reads, the first grant is req_ready=0001.
- Write then read: req 2 writes 0xBEEF to addr 0x10, then the next cycle reads 0x10 -> rsp_valid pulses 1 cycle after the read handshake, with rsp_id=2 and rsp_data=0xBEEF.
- Round-robin fairness: all 4 requesters hold reads of addrs 0..3 (preloaded 0xA0..0xA3) continuously -> grants in order 0,1,2,3,0. Responses show ids 0,1,2,3 with matching data on consecutive cycles.
- Concurrent ports: req 0 writes 0x1234 to addr 5 while req 3 reads addr 5 (old value 0x0000) in the same cycle -> both ready. Response is id=3, data=0x0000. A read of addr 5 on the following cycle returns 0x1234.
- Pointer wrap and hold: with wr_ptr=3 and only req 1 writing -> grant 1, next wr_ptr=2. Idle cycles leave the pointer at 2. Then reqs 0 and 2 write together -> req 2 granted first.
- Reset mid-operation: assert rst_n=0 in the cycle right after a read handshake -> no rsp_valid is ever produced for that read, and both pointers read 0 after release.
